// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
package pipe_adder_pkg;

  // Default datapath word width.
  localparam int WORD = 32;

  // Operation encoding carried on the sub input.
  typedef enum logic {
    ADD_OP_ADD = 1'b0,
    ADD_OP_SUB = 1'b1
  } add_op_e;

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// master = producer/consumer side, slave = the adder itself.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = WORD
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] add_out;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, sub, Ain, Bin, out_ready,
    input  in_ready, out_valid, add_out, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, sub, Ain, Bin, out_ready,
    output in_ready, out_valid, add_out, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipe_adder_add_slice.sv
// One SW-bit slice of the pipelined adder: combinational slice sum,
// registered carry and valid bit, both frozen while en is low.
module pipe_adder_add_slice #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          vin,
  input  logic          cin,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  output logic [SW-1:0] sum,
  output logic          cout_q,
  output logic          vld_q
);
  logic cout;

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

  // Carry only updates on a real beat so a bubble never corrupts the held value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else if (en) begin
      vld_q <= vin;
      if (vin) cout_q <= cout;
    end
  end
endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: WIDTH-bit add split into STAGES carry-linked
// slices, one slice per cycle, valid/ready handshake, one op per cycle.
// Optional: define ADDER_SAT_EN to clamp add_out on signed overflow.
// WIDTH must be a multiple of STAGES.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = WORD,
  parameter int STAGES = 4
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic                      advance;
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0]           cy_pipe;
  logic [STAGES-1:0][SW-1:0] slice_sum;
  logic [WIDTH-1:0]          b_eff;
  logic [WIDTH-1:0]          raw_res;
  logic [WIDTH-1:0]          res_next;
  logic                      a_msb, b_msb, ovf_next;
  logic [WIDTH-1:0]          add_q;
  logic                      ovf_q, zero_q;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign advance      = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtract = A + ~B + 1: invert B up front, the +1 enters as slice-0 carry.
  assign vld_pipe[0] = bus.in_valid;
  assign cy_pipe[0]  = (bus.sub == ADD_OP_SUB);
  assign b_eff       = cy_pipe[0] ? ~bus.Bin : bus.Bin;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be added when the beat reaches this stage.
      localparam int OW = WIDTH - k * SW;
      logic [OW-1:0]         a_in, b_in;
      logic [(k+1)*SW-1:0]   r_cat;

      if (k == 0) begin : g_src
        assign a_in  = bus.Ain;
        assign b_in  = b_eff;
        assign r_cat = slice_sum[0];
      end else begin : g_src
        assign a_in  = g_stage[k-1].g_skew.a_q;
        assign b_in  = g_stage[k-1].g_skew.b_q;
        assign r_cat = {slice_sum[k], g_stage[k-1].g_skew.r_q};
      end

      pipe_adder_add_slice #(.SW(SW)) u_slice (
        .clk    (clk),
        .rst    (rst),
        .en     (advance),
        .vin    (vld_pipe[k]),
        .cin    (cy_pipe[k]),
        .a      (a_in[SW-1:0]),
        .b      (b_in[SW-1:0]),
        .sum    (slice_sum[k]),
        .cout_q (cy_pipe[k+1]),
        .vld_q  (vld_pipe[k+1])
      );

      if (k < STAGES - 1) begin : g_skew
        logic [OW-SW-1:0]    a_q, b_q;
        logic [(k+1)*SW-1:0] r_q;

        // Skew: unconsumed upper operand slices and finished lower result slices.
        always_ff @(posedge clk) begin
          if (advance && vld_pipe[k]) begin
            a_q <= a_in[OW-1:SW];
            b_q <= b_in[OW-1:SW];
            r_q <= r_cat;
          end
        end
      end else begin : g_last
        assign raw_res = r_cat;
        assign a_msb   = a_in[SW-1];
        assign b_msb   = b_in[SW-1];
      end
    end
  endgenerate

  assign ovf_next = (a_msb == b_msb) && (slice_sum[STAGES-1][SW-1] != a_msb);

  // Final value presented on add_out (clamped on overflow when enabled).
  always_comb begin
    res_next = raw_res;
`ifdef ADDER_SAT_EN
    if (ovf_next)
      res_next = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Output register: loads only with a real beat, so bubbles leave it holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance && vld_pipe[STAGES-1]) begin
      add_q  <= res_next;
      ovf_q  <= ovf_next;
      zero_q <= (res_next == '0);
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.add_out   = add_q;
  assign bus.carry_out = cy_pipe[STAGES];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: STAGES=4 and STAGES=1 instances,
// arithmetic reference model plus directed literal vectors.
module tb_pipe_adder;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          acc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv4 = 1'b0, iv1 = 1'b0, sub = 1'b0, ordy = 1'b1;
  logic [31:0] a = '0, b = '0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(32)) bus4 ();
  pipe_adder_if #(.WIDTH(32)) bus1 ();

  assign bus4.in_valid = iv4;  assign bus1.in_valid = iv1;
  assign bus4.sub = sub;       assign bus1.sub = sub;
  assign bus4.Ain = a;         assign bus1.Ain = a;
  assign bus4.Bin = b;         assign bus1.Bin = b;
  assign bus4.out_ready = ordy; assign bus1.out_ready = ordy;

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  pipe_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic        ovld[2], irdy[2], ivd[2], oc[2], oo[2], oz[2];
  logic [31:0] ores[2];
  assign ovld[0] = bus4.out_valid; assign ovld[1] = bus1.out_valid;
  assign irdy[0] = bus4.in_ready;  assign irdy[1] = bus1.in_ready;
  assign ivd[0]  = iv4;            assign ivd[1]  = iv1;
  assign oc[0]   = bus4.carry_out; assign oc[1]   = bus1.carry_out;
  assign oo[0]   = bus4.overflow;  assign oo[1]   = bus1.overflow;
  assign oz[0]   = bus4.zero;      assign oz[1]   = bus1.zero;
  assign ores[0] = bus4.add_out;   assign ores[1] = bus1.add_out;

  int   n_pass = 0, n_tot = 0;
  ent_t q4[$], q1[$];
  ent_t last[2];
  int   cyc = 0;

  // Driver-owned flags read by the compare process.
  logic chk_lat = 1'b0, lit_go = 1'b0, end_go = 1'b0, drv_timeout = 1'b0;
  ent_t lit_exp;

  // Reference: true signed result and 33-bit unsigned sum from plain arithmetic.
  function automatic ent_t model(input logic [31:0] x, input logic [31:0] y, input logic s, input int t);
    ent_t   e;
    longint sx, sy, tr;
    logic [32:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    tr = s ? sx - sy : sx + sy;
    u  = s ? ({1'b0, x} + {1'b0, ~y} + 33'd1) : ({1'b0, x} + {1'b0, y});
    e.res = u[31:0];
    e.c   = u[32];
    e.v   = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
`ifdef ADDER_SAT_EN
    if (e.v) e.res = (tr < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.z   = (e.res == 32'd0);
    e.acc = t;
    return e;
  endfunction

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL s%0d %s: got %0h need %0h", (d == 0) ? 4 : 1, nm, act, exp);
  endtask

  // Compare process: handshake rule, reset state, scoreboard, literal pins.
  initial begin
    logic rst_d;
    ent_t e;
    rst_d = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q4.delete();
        q1.delete();
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (rst_d) begin
            chk(d, "rst out_valid", 32'(ovld[d]), 32'd0);
            chk(d, "rst in_ready",  32'(irdy[d]), 32'd1);
            chk(d, "rst add_out",   ores[d],      32'd0);
            chk(d, "rst carry",     32'(oc[d]),   32'd0);
            chk(d, "rst overflow",  32'(oo[d]),   32'd0);
            chk(d, "rst zero",      32'(oz[d]),   32'd0);
          end
          chk(d, "in_ready", 32'(irdy[d]), 32'(!ovld[d] || ordy));
          if (ovld[d] && ordy) begin
            if (((d == 0) ? q4.size() : q1.size()) == 0) begin
              n_tot++;
              $display("FAIL s%0d spurious beat: got %0h need none", (d == 0) ? 4 : 1, ores[d]);
            end else begin
              if (d == 0) e = q4.pop_front(); else e = q1.pop_front();
              chk(d, "add_out",  ores[d],     e.res);
              chk(d, "carry",    32'(oc[d]),  32'(e.c));
              chk(d, "overflow", 32'(oo[d]),  32'(e.v));
              chk(d, "zero",     32'(oz[d]),  32'(e.z));
              if (chk_lat) chk(d, "latency", 32'(cyc - e.acc), (d == 0) ? 32'd4 : 32'd1);
              last[d] = '{res: ores[d], c: oc[d], v: oo[d], z: oz[d], acc: cyc};
            end
          end
          if (ivd[d] && irdy[d]) begin
            if (d == 0) q4.push_back(model(a, b, sub, cyc));
            else        q1.push_back(model(a, b, sub, cyc));
          end
          if (lit_go) begin
            chk(d, "lit add_out",  last[d].res,     lit_exp.res);
            chk(d, "lit carry",    32'(last[d].c),  32'(lit_exp.c));
            chk(d, "lit overflow", 32'(last[d].v),  32'(lit_exp.v));
            chk(d, "lit zero",     32'(last[d].z),  32'(lit_exp.z));
          end
        end
        if (end_go) begin
          chk(0, "queue empty", 32'(q4.size()), 32'd0);
          chk(1, "queue empty", 32'(q1.size()), 32'd0);
          chk(0, "driver timeout", 32'(drv_timeout), 32'd0);
        end
      end
      rst_d = rst;
    end
  end

  // One beat into both instances, drain, then pin the result to literals.
  task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                         input logic [31:0] er, input logic ec, input logic ev, input logic ez);
    chk_lat = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b1; iv1 = 1'b1; a = ta; b = tb_v; sub = ts;
    @(posedge clk); #1;
    iv4 = 1'b0; iv1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    lit_exp = '{res: er, c: ec, v: ev, z: ez, acc: 0};
    lit_go  = 1'b1;
    @(posedge clk); #1;
    lit_go  = 1'b0;
    chk_lat = 1'b0;
  endtask

  logic [31:0] sa[8] = '{32'd89, 32'd1000, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd123456, 32'd0, 32'h1234_5678};
  logic [31:0] sb[8] = '{32'd120, 32'd234, 32'd2, 32'd7, 32'd1, 32'd654321, 32'd0, 32'h1111_1111};
  logic        ss[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  localparam logic [31:0] POS_OVF = `ifdef ADDER_SAT_EN 32'h7FFF_FFFF `else 32'h8000_0000 `endif;
  localparam logic [31:0] NEG_OVF = `ifdef ADDER_SAT_EN 32'h8000_0000 `else 32'h7FFF_FFFF `endif;

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_one(32'd2,          32'd10, 1'b0, 32'd12,          1'b0, 1'b0, 1'b0);
    run_one(32'd24567,      32'd4510, 1'b0, 32'd29077,     1'b0, 1'b0, 1'b0);
    run_one(32'd5,          32'd10, 1'b1, 32'hFFFF_FFFB,   1'b0, 1'b0, 1'b0);
    run_one(32'd10,         32'd10, 1'b1, 32'd0,           1'b1, 1'b0, 1'b1);
    run_one(32'h0000_FFFF,  32'd1,  1'b0, 32'h0001_0000,   1'b0, 1'b0, 1'b0);
    run_one(32'hFFFF_FFFF,  32'd1,  1'b0, 32'd0,           1'b1, 1'b0, 1'b1);
    run_one(32'h7FFF_FFFF,  32'd1,  1'b0, POS_OVF,         1'b0, 1'b1, 1'b0);
    run_one(32'h8000_0000,  32'd1,  1'b1, NEG_OVF,         1'b1, 1'b1, 1'b0);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    i = 0;
    for (int c = 0; c < 60 && i < 8; c++) begin
      @(posedge clk); #1;
      iv4 = 1'b1; a = sa[i]; b = sb[i]; sub = ss[i];
      ordy = !(c >= 5 && c < 8);
      @(negedge clk);
      if (bus4.in_ready) i++;
    end
    @(posedge clk); #1;
    iv4 = 1'b0; ordy = 1'b1;
    if (i < 8) drv_timeout = 1'b1;
    repeat (10) @(posedge clk);

    // Reset with three beats in flight: none may emerge afterwards.
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      iv4 = 1'b1; a = 32'd100 + 32'(j); b = 32'd1; sub = 1'b0;
    end
    @(posedge clk); #1;
    iv4 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);

    #1 end_go = 1'b1;
    @(posedge clk); #1 end_go = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
